// File: rtl/controle_multiciclo_p.sv
// Multicycle Moore control unit for the MIPS-subset datapath.
// Optional mult/div handshake enabled by defining CONTROLE_MULTDIV_EN.
module controle_multiciclo_p #(
   parameter int unsigned FETCH_WAIT = 3,
   parameter int unsigned STATE_W    = 6
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               alu_overflow,
   input  logic               alu_zero,
   input  logic               md_done,
   input  logic               md_div0,
   output logic [STATE_W-1:0] estado,
   output logic               pc_write,
   output logic               ir_write,
   output logic [1:0]         mem_add,
   output logic [2:0]         pc_source,
   output logic [2:0]         alu_control,
   output logic               alu_src_a,
   output logic [2:0]         alu_src_b,
   output logic               reg_a_write,
   output logic               reg_b_write,
   output logic               reg_write,
   output logic [2:0]         reg_dest,
   output logic [3:0]         reg_data,
   output logic               mux_hi_lo,
   output logic               epc_write,
   output logic [1:0]         exc_cause,
   output logic               md_start,
   output logic               md_op
);

   typedef enum logic [5:0] {
      StFetch     = 6'd0,
      StDecode    = 6'd1,
      StAluAdd    = 6'd2,
      StAluSub    = 6'd3,
      StAluAnd    = 6'd4,
      StAluWb     = 6'd5,
      StSlt       = 6'd6,
      StJr        = 6'd7,
      StBreak     = 6'd8,
      StRte       = 6'd9,
      StMfhi      = 6'd10,
      StMflo      = 6'd11,
      StJ         = 6'd12,
      StJal1      = 6'd13,
      StJal2      = 6'd14,
      StBeq       = 6'd15,
      StBne       = 6'd16,
      StExc1      = 6'd17,
      StExc2      = 6'd18,
      StMdMult    = 6'd19,
      StMdDiv     = 6'd20,
      StMdWaitMul = 6'd21,
      StMdWaitDiv = 6'd22
   } state_e;

   localparam logic [3:0] FetchLast = 4'(FETCH_WAIT - 1);

   state_e     state_q, state_d;
   logic [3:0] fetch_cnt_q, fetch_cnt_d;
   logic [1:0] cause_q, cause_d;

`ifndef CONTROLE_MULTDIV_EN
   logic unused_md;
   assign unused_md = md_done ^ md_div0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= StFetch;
         fetch_cnt_q <= 4'd0;
         cause_q     <= 2'b00;
      end else begin
         state_q     <= state_d;
         fetch_cnt_q <= fetch_cnt_d;
         cause_q     <= cause_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      fetch_cnt_d = fetch_cnt_q;
      cause_d     = cause_q;
      case (state_q)
         StFetch: begin
            if (fetch_cnt_q == FetchLast) begin
               fetch_cnt_d = 4'd0;
               state_d     = StDecode;
            end else begin
               fetch_cnt_d = fetch_cnt_q + 4'd1;
            end
         end
         StDecode: begin
            case (opcode)
               6'd0: begin
                  case (funct)
                     6'h20: state_d = StAluAdd;
                     6'h22: state_d = StAluSub;
                     6'h24: state_d = StAluAnd;
                     6'h2a: state_d = StSlt;
                     6'h08: state_d = StJr;
                     6'h0d: state_d = StBreak;
                     6'h13: state_d = StRte;
                     6'h10: state_d = StMfhi;
                     6'h12: state_d = StMflo;
`ifdef CONTROLE_MULTDIV_EN
                     6'h18: state_d = StMdMult;
                     6'h1a: state_d = StMdDiv;
`endif
                     default: begin
                        state_d = StExc1;
                        cause_d = 2'b00;
                     end
                  endcase
               end
               6'd2:    state_d = StJ;
               6'd3:    state_d = StJal1;
               6'd4:    state_d = StBeq;
               6'd5:    state_d = StBne;
               default: begin
                  state_d = StExc1;
                  cause_d = 2'b00;
               end
            endcase
         end
         StAluAdd, StAluSub: begin
            if (alu_overflow) begin
               state_d = StExc1;
               cause_d = 2'b01;
            end else begin
               state_d = StAluWb;
            end
         end
         StAluAnd: state_d = StAluWb;
         StJal1:   state_d = StJal2;
         StExc1:   state_d = StExc2;
`ifdef CONTROLE_MULTDIV_EN
         StMdMult: state_d = StMdWaitMul;
         StMdDiv:  state_d = StMdWaitDiv;
         StMdWaitMul: begin
            if (md_done) state_d = StFetch;
         end
         StMdWaitDiv: begin
            if (md_done) begin
               if (md_div0) begin
                  state_d = StExc1;
                  cause_d = 2'b10;
               end else begin
                  state_d = StFetch;
               end
            end
         end
`endif
         default: state_d = StFetch;
      endcase
   end

   // Outputs follow the state register; reset forces them low without waiting for an edge.
   always_comb begin
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      mem_add     = 2'b00;
      pc_source   = 3'b000;
      alu_control = 3'b000;
      alu_src_a   = 1'b0;
      alu_src_b   = 3'b000;
      reg_a_write = 1'b0;
      reg_b_write = 1'b0;
      reg_write   = 1'b0;
      reg_dest    = 3'b000;
      reg_data    = 4'b0000;
      mux_hi_lo   = 1'b0;
      epc_write   = 1'b0;
      md_start    = 1'b0;
      md_op       = 1'b0;
      if (!reset) begin
         case (state_q)
            StFetch: begin
               alu_src_b   = 3'b011;
               alu_control = 3'b001;
               if (fetch_cnt_q == FetchLast) begin
                  pc_write  = 1'b1;
                  ir_write  = 1'b1;
                  pc_source = 3'b001;
               end
            end
            StDecode: begin
               alu_src_b   = 3'b100;
               alu_control = 3'b001;
               reg_a_write = 1'b1;
               reg_b_write = 1'b1;
            end
            StAluAdd, StAluSub, StAluAnd: begin
               alu_src_a   = 1'b1;
               alu_control = (state_q == StAluAdd) ? 3'b001 :
                             (state_q == StAluSub) ? 3'b010 : 3'b011;
            end
            StAluWb: begin
               reg_write = 1'b1;
               reg_dest  = 3'b001;
            end
            StSlt: begin
               reg_write   = 1'b1;
               reg_dest    = 3'b001;
               reg_data    = 4'b0010;
               alu_control = 3'b111;
               alu_src_a   = 1'b1;
            end
            StJr: begin
               pc_write  = 1'b1;
               pc_source = 3'b001;
               alu_src_a = 1'b1;
            end
            StBreak: begin
               pc_write    = 1'b1;
               pc_source   = 3'b001;
               alu_src_b   = 3'b011;
               alu_control = 3'b010;
            end
            StRte: begin
               pc_write  = 1'b1;
               pc_source = 3'b010;
            end
            StMfhi, StMflo: begin
               reg_write = 1'b1;
               reg_dest  = 3'b001;
               reg_data  = 4'b0001;
               mux_hi_lo = (state_q == StMflo);
            end
            StJ: pc_write = 1'b1;
            StJal1: alu_src_b = 3'b011;
            StJal2: begin
               reg_write = 1'b1;
               reg_dest  = 3'b010;
               pc_write  = 1'b1;
            end
            StBeq, StBne: begin
               alu_src_a   = 1'b1;
               alu_control = 3'b010;
               pc_write    = (state_q == StBeq) ? alu_zero : !alu_zero;
            end
            StExc1: begin
               epc_write   = 1'b1;
               alu_src_b   = 3'b011;
               alu_control = 3'b010;
            end
            StExc2: begin
               pc_write  = 1'b1;
               pc_source = 3'b011;
            end
`ifdef CONTROLE_MULTDIV_EN
            StMdMult: md_start = 1'b1;
            StMdDiv: begin
               md_start = 1'b1;
               md_op    = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   assign estado    = STATE_W'(state_q);
   assign exc_cause = cause_q;

endmodule

// File: tb/tb_controle_multiciclo_p.sv
// Directed bench for controle_multiciclo_p; covers the mult/div path when
// CONTROLE_MULTDIV_EN is defined.
module tb_controle_multiciclo_p;

   localparam int unsigned FW = 3;

   logic       clock, reset;
   logic [5:0] opcode, funct;
   logic       alu_overflow, alu_zero, md_done, md_div0;
   logic [5:0] estado;
   logic       pc_write, ir_write, alu_src_a, reg_a_write, reg_b_write, reg_write;
   logic       mux_hi_lo, epc_write, md_start, md_op;
   logic [1:0] mem_add, exc_cause;
   logic [2:0] pc_source, alu_control, alu_src_b, reg_dest;
   logic [3:0] reg_data;

   int n_checks = 0;
   int n_pass   = 0;

   controle_multiciclo_p #(.FETCH_WAIT(FW), .STATE_W(6)) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
      .alu_overflow(alu_overflow), .alu_zero(alu_zero), .md_done(md_done),
      .md_div0(md_div0), .estado(estado), .pc_write(pc_write), .ir_write(ir_write),
      .mem_add(mem_add), .pc_source(pc_source), .alu_control(alu_control),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_a_write(reg_a_write),
      .reg_b_write(reg_b_write), .reg_write(reg_write), .reg_dest(reg_dest),
      .reg_data(reg_data), .mux_hi_lo(mux_hi_lo), .epc_write(epc_write),
      .exc_cause(exc_cause), .md_start(md_start), .md_op(md_op)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Every control output concatenated; all-zero means idle.
   function automatic logic [31:0] ctrl_bus();
      return {4'b0, pc_write, ir_write, mem_add, pc_source, alu_control, alu_src_a,
              alu_src_b, reg_a_write, reg_b_write, reg_write, reg_dest, reg_data,
              mux_hi_lo, epc_write, md_start, md_op};
   endfunction

   // Runs FW fetch cycles; returns positioned in DECODE.
   task automatic do_fetch(input logic [5:0] op, input logic [5:0] fn);
      for (int i = 0; i < int'(FW); i++) begin
         check("fetch_state", {26'b0, estado}, 32'd0);
         check("fetch_pc_write", {31'b0, pc_write}, {31'b0, i == int'(FW) - 1});
         check("fetch_ir_write", {31'b0, ir_write}, {31'b0, i == int'(FW) - 1});
         opcode = op;
         funct  = fn;
         tick();
      end
      check("decode_ab_write", {30'b0, reg_a_write, reg_b_write}, 32'd3);
      check("decode_src_b", {29'b0, alu_src_b}, 32'd4);
   endtask

   initial begin
      reset = 1'b1;
      opcode = '0; funct = '0;
      alu_overflow = 0; alu_zero = 0; md_done = 0; md_div0 = 0;
      #12;
      check("reset_ctrl", ctrl_bus(), 32'd0);
      check("reset_state", {26'b0, estado}, 32'd0);
      check("reset_cause", {30'b0, exc_cause}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      #0;
      check("fetch_src_b", {29'b0, alu_src_b}, 32'd3);
      check("fetch_alu", {29'b0, alu_control}, 32'd1);

      // add, no overflow: cycles 1-3 fetch, 4 decode, 5 ex, 6 wb, 7 fetch
      do_fetch(6'd0, 6'h20);
      tick();
      check("add_ex_src_a", {31'b0, alu_src_a}, 32'd1);
      check("add_ex_alu", {29'b0, alu_control}, 32'd1);
      tick();
      check("add_wb_write", {31'b0, reg_write}, 32'd1);
      check("add_wb_dest", {29'b0, reg_dest}, 32'd1);
      check("add_wb_data", {28'b0, reg_data}, 32'd0);
      tick();
      check("add_back_fetch", {26'b0, estado}, 32'd0);

      // add with overflow
      do_fetch(6'd0, 6'h20);
      tick();
      alu_overflow = 1'b1;
      tick();
      alu_overflow = 1'b0;
      check("ovf_epc_write", {31'b0, epc_write}, 32'd1);
      check("ovf_cause", {30'b0, exc_cause}, 32'd1);
      check("ovf_no_reg_write", {31'b0, reg_write}, 32'd0);
      check("exc1_alu", {29'b0, alu_control}, 32'd2);
      tick();
      check("exc2_pc_write", {31'b0, pc_write}, 32'd1);
      check("exc2_pc_source", {29'b0, pc_source}, 32'd3);
      check("exc2_no_reg_write", {31'b0, reg_write}, 32'd0);
      tick();
      check("exc_back_fetch", {26'b0, estado}, 32'd0);

      // reset during fetch cycle 2
      tick();
      #2 reset = 1'b1;
      #1;
      check("rst_fetch_ctrl", ctrl_bus(), 32'd0);
      check("rst_fetch_state", {26'b0, estado}, 32'd0);
      check("rst_fetch_cause", {30'b0, exc_cause}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      do_fetch(6'd0, 6'h24);
      tick();
      check("and_alu", {29'b0, alu_control}, 32'd3);
      alu_overflow = 1'b1;
      tick();
      alu_overflow = 1'b0;
      check("and_no_trap_wb", {31'b0, reg_write}, 32'd1);
      check("and_no_trap_epc", {31'b0, epc_write}, 32'd0);
      // reset mid-writeback drops reg_write immediately
      #2 reset = 1'b1;
      #1;
      check("rst_wb_reg_write", {31'b0, reg_write}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

`ifdef CONTROLE_MULTDIV_EN
      do_fetch(6'd0, 6'h1a);
      tick();
      check("div_start", {30'b0, md_start, md_op}, 32'd3);
      tick();
      check("div_wait_start", {31'b0, md_start}, 32'd0);
      check("div_wait_idle", ctrl_bus(), 32'd0);
      for (int i = 0; i < 30; i++) tick();
      check("div_still_wait", ctrl_bus(), 32'd0);
      md_done = 1'b1;
      md_div0 = 1'b1;
      tick();
      md_done = 1'b0;
      md_div0 = 1'b0;
      check("div0_epc_write", {31'b0, epc_write}, 32'd1);
      check("div0_cause", {30'b0, exc_cause}, 32'd2);
      tick();
      check("div0_exc2", {31'b0, pc_write}, 32'd1);
      tick();
`else
      do_fetch(6'd0, 6'h1a);
      tick();
      check("div_inval_epc", {31'b0, epc_write}, 32'd1);
      check("div_inval_cause", {30'b0, exc_cause}, 32'd0);
      check("div_inval_md", {30'b0, md_start, md_op}, 32'd0);
      tick();
      tick();
`endif

      // BEQ taken, BNE not taken
      do_fetch(6'd4, 6'h00);
      tick();
      alu_zero = 1'b1;
      #0;
      check("beq_pc_write", {31'b0, pc_write}, 32'd1);
      check("beq_pc_source", {29'b0, pc_source}, 32'd0);
      check("beq_alu", {29'b0, alu_control}, 32'd2);
      tick();
      alu_zero = 1'b0;
      check("beq_back_fetch", {26'b0, estado}, 32'd0);
      do_fetch(6'd5, 6'h00);
      tick();
      alu_zero = 1'b1;
      #0;
      check("bne_pc_write", {31'b0, pc_write}, 32'd0);
      tick();
      alu_zero = 1'b0;
      check("bne_back_fetch", {26'b0, estado}, 32'd0);

      // JAL
      do_fetch(6'd3, 6'h00);
      tick();
      check("jal1_src_b", {29'b0, alu_src_b}, 32'd3);
      check("jal1_alu", {29'b0, alu_control}, 32'd0);
      tick();
      check("jal2_dest_pcw", {27'b0, reg_dest, pc_write, reg_write}, {27'b0, 3'b010, 2'b11});
      tick();

      // invalid opcode 0x3f after an overflow-caused exception
      do_fetch(6'd0, 6'h20);
      tick();
      alu_overflow = 1'b1;
      tick();
      alu_overflow = 1'b0;
      check("pre_inval_cause", {30'b0, exc_cause}, 32'd1);
      tick();
      tick();
      do_fetch(6'h3f, 6'h00);
      tick();
      check("inval_epc", {31'b0, epc_write}, 32'd1);
      check("inval_cause", {30'b0, exc_cause}, 32'd0);
      tick();
      tick();

      // MFLO and SLT
      do_fetch(6'd0, 6'h12);
      tick();
      check("mflo", {23'b0, reg_write, reg_dest, reg_data, mux_hi_lo}, {23'b0, 1'b1, 3'b001, 4'b0001, 1'b1});
      tick();
      do_fetch(6'd0, 6'h2a);
      tick();
      check("slt", {24'b0, reg_data, alu_control, alu_src_a}, {24'b0, 4'b0010, 3'b111, 1'b1});
      tick();
      check("slt_back_fetch", {26'b0, estado}, 32'd0);

`ifdef CONTROLE_MULTDIV_EN
      // reset during MD_WAIT, then a stray md_done in FETCH is ignored
      do_fetch(6'd0, 6'h18);
      tick();
      check("mult_start", {30'b0, md_start, md_op}, 32'd2);
      tick();
      #2 reset = 1'b1;
      #1;
      check("rst_mdwait_ctrl", ctrl_bus(), 32'd0);
      check("rst_mdwait_state", {26'b0, estado}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      md_done = 1'b1;
      tick();
      md_done = 1'b0;
      check("md_done_ignored", {26'b0, estado}, 32'd0);
      tick();
      check("fetch_after_rst_pcw", {31'b0, pc_write}, 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/controle_multiciclo_p.md
Name: controle_multiciclo_p

Overview:
- Parametrised multicycle control unit for the MIPS-subset datapath; successor of the current fixed three-cycle-fetch controller.
- Moore FSM driven by the latched instruction's opcode/funct.
- Adds configurable memory-latency fetch, branch support and precise exceptions (invalid opcode, overflow, divide-by-zero) with EPC capture.
- Adds a start/done handshake to the mult/div unit.

Parameters:
- FETCH_WAIT, 3, cycles of the fetch state; legal range 1..15.
- STATE_W, 6, width of the estado output.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  6  instruction[31:26] from IR.
- funct  in  6  instruction[5:0] from IR.
- alu_overflow  in  1  ALU overflow flag.
- alu_zero  in  1  ALU zero flag.
- md_done  in  1  mult/div result valid, one-cycle pulse.
- md_div0  in  1  divisor zero; valid with md_done.
- estado  out  STATE_W  current state.
- pc_write  out  1  PC load.
- ir_write  out  1  IR load.
- mem_add  out  2  memory address mux (00 = PC).
- pc_source  out  3  000 = ALUOut/jump target, 001 = ALU result, 010 = EPC, 011 = exception vector.
- alu_control  out  3  000 = pass A, 001 = add, 010 = sub, 011 = and, 111 = slt.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  3  000 = B, 011 = const 4, 100 = imm<<2.
- reg_a_write  out  1  A register load.
- reg_b_write  out  1  B register load.
- reg_write  out  1  register file write.
- reg_dest  out  3  001 = rd, 010 = $31.
- reg_data  out  4  0000 = ALUOut, 0001 = HI/LO, 0010 = slt.
- mux_hi_lo  out  1  0 = HI, 1 = LO.
- epc_write  out  1  EPC load.
- exc_cause  out  2  00 = opcode, 01 = overflow, 10 = div0; held until the next exception.
- md_start  out  1  mult/div start pulse.
- md_op  out  1  0 = mult, 1 = div.

Behaviour:
- Reset (async): estado = FETCH, fetch_cnt = 0, exc_cause = 00, every control output 0.
- Outputs are decoded from the state register only (Moore). Any signal not listed for a state is 0.
- FETCH:
  - mem_add = 00, alu_src_a = 0, alu_src_b = 011, alu_control = 001.
  - fetch_cnt increments each cycle.
  - pc_write, ir_write and pc_source = 001 are asserted only when fetch_cnt == FETCH_WAIT-1; the FSM then clears the counter and goes to DECODE. PC therefore advances exactly once per instruction.
- DECODE:
  - alu_src_a = 0, alu_src_b = 100, alu_control = 001, reg_a_write = reg_b_write = 1.
  - Dispatch on opcode:
    - 0 → R-type by funct.
    - 2 → J.
    - 3 → JAL1.
    - 4 → BEQ.
    - 5 → BNE.
    - else → EXC1 with cause 00.
  - Unknown funct → EXC1 with cause 00.
- R-type dispatch (funct):
  - 0x20 add, 0x22 sub, 0x24 and → ALU_EX: alu_src_a = 1, alu_src_b = 000, op per funct.
  - ALU_EX → ALU_WB, or EXC1 with cause 01 if alu_overflow is set for add/sub. and never traps.
  - ALU_WB: reg_write, reg_dest = 001, reg_data = 0000 → FETCH.
  - 0x2a SLT: single cycle; reg_write, reg_dest = 001, reg_data = 0010, alu_control = 111, alu_src_a = 1 → FETCH.
  - 0x08 JR: pc_write, pc_source = 001, alu_src_a = 1, alu_control = 000 → FETCH.
  - 0x0d BREAK: pc_write, pc_source = 001, alu_src_a = 0, alu_src_b = 011, alu_control = 010 (PC-4) → FETCH.
  - 0x13 RTE: pc_write, pc_source = 010 → FETCH.
  - 0x10 MFHI / 0x12 MFLO: reg_write, reg_dest = 001, reg_data = 0001, mux_hi_lo = 0/1 → FETCH.
- J: pc_write, pc_source = 000 → FETCH.
- JAL1: alu_src_a = 0, alu_src_b = 011, alu_control = 000 (ALUOut = PC).
- JAL2: reg_write, reg_dest = 010, reg_data = 0000, pc_write, pc_source = 000 → FETCH.
- BEQ / BNE:
  - alu_src_a = 1, alu_src_b = 000, alu_control = 010, pc_source = 000 (ALUOut = target from DECODE).
  - pc_write = alu_zero for BEQ, !alu_zero for BNE → FETCH.
- EXC1:
  - epc_write = 1, alu_src_a = 0, alu_src_b = 011, alu_control = 010 (EPC = PC-4).
  - exc_cause is latched on entry → EXC2.
- EXC2: pc_write, pc_source = 011 → FETCH.
- Timing and ordering:
  - Total latency per instruction = FETCH_WAIT + 1 (DECODE) + execute states.
  - Reset asserted mid-instruction aborts immediately, with no partial writes after the reset edge.

Optional Feature:
- Macro: CONTROLE_MULTDIV_EN.
- When defined:
  - funct 0x18 (mult) / 0x1a (div) → MD_START, which asserts md_start for one cycle with md_op = 0/1.
  - MD_WAIT holds all outputs 0 until md_done.
  - On md_done: if md_div0 && md_op → EXC1 with cause 10, else → FETCH.
  - A pending md_done is ignored in every state other than MD_WAIT.
- When undefined: 0x18/0x1a decode as invalid → EXC1 with cause 00. md_start and md_op are tied 0.

Test Plan:
- Reset, then FETCH_WAIT = 3 with add (op 0, funct 0x20), no overflow → pc_write high exactly 1 cycle in the 3rd fetch cycle; reg_write with reg_dest = 001 in cycle 6; back to FETCH in cycle 7.
- add with alu_overflow = 1 in ALU_EX → EXC1 asserts epc_write, exc_cause = 01; EXC2 asserts pc_write with pc_source = 011; no reg_write.
- BEQ with alu_zero = 1 → pc_write = 1; BNE with alu_zero = 1 → pc_write = 0. Both return to FETCH.
- JAL (opcode 3) → JAL2 asserts reg_dest = 010 together with pc_write; opcode 0x3f → exc_cause = 00.
- CONTROLE_MULTDIV_EN, div with md_done after 32 cycles and md_div0 = 1 → md_start is a single pulse, then EXC1 with cause 10. Same case without the macro → EXC1 with cause 00 directly from DECODE.
- Assert reset during MD_WAIT and during FETCH cycle 2 → estado = FETCH and all outputs 0 asynchronously; the next fetch starts with fetch_cnt = 0.
